id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 16-bit RISC-V core, directly downstream of the register bank read ports.
- Captures decoded control, register-bank read data and immediate; presents them to EX.
- Owns load-use hazard detection (stalls IF/ID and inserts a bubble), branch flush, downstream hold, and EX-side operand forwarding from the MEM and WB stages.
- Distance-3 forwarding (WB to ID) stays in the register bank.

Parameters:
- word_size, 16, operand/immediate width
- addr_width, 4, register address width (16 registers, R0 hard zero)
- alu_op_width, 4, ALU opcode width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  addr_width  decoded register addresses
- id_rs1_data, id_rs2_data  in  word_size  register-bank read data
- id_imm  in  word_size  decoded immediate
- id_alu_op  in  alu_op_width  ALU operation
- id_we, id_mem_read, id_mem_write  in  1  decoded control
- flush  in  1  branch taken in EX; kill the ID instruction
- ex_hold  in  1  downstream busy; freeze EX
- mem_valid, mem_we  in  1  MEM-stage instruction valid / writes rd
- mem_rd_addr  in  addr_width  MEM destination
- mem_result  in  word_size  MEM ALU result
- wb_we  in  1  WB write enable (same as register-bank we)
- wb_rd_addr  in  addr_width  WB destination
- wb_data  in  word_size  WB write data
- stall_id  out  1  hold PC and IF/ID this cycle
- ex_valid  out  1  EX instruction valid
- ex_rd_addr  out  addr_width
- ex_op_a, ex_op_b  out  word_size  forwarded rs1/rs2 values
- ex_imm  out  word_size
- ex_alu_op  out  alu_op_width
- ex_we, ex_mem_read, ex_mem_write  out  1  (all gated by ex_valid)

Behaviour:
- Registered state: valid_q, rs1/rs2/rd addresses, op_a_q, op_b_q, imm, alu_op, we, mem_read, mem_write.
- Reset: all registers and all outputs are 0; stall_id = 0.
- Next-state priority each posedge: rst > flush > ex_hold > load-use > load.
  - flush: load a bubble (valid_q=0, we/mem_read/mem_write=0). This wins over ex_hold.
  - ex_hold: keep all fields. op_a_q/op_b_q load the current forwarded ex_op_a/ex_op_b, so a WB value retiring during the hold is not lost.
  - load-use: load a bubble. ID re-presents the same instruction next cycle, and the register bank re-reads it.
  - load: capture all id_* fields; valid_q = id_valid.
- Load-use condition: valid_q & mem_read_q & rd_q!=0 & id_valid & (rd_q==id_rs1_addr | rd_q==id_rs2_addr).
- stall_id (combinational) = !flush & (ex_hold | load-use). Exactly one bubble is inserted per load-use.
- Forwarding, per operand (combinational), with address rs:
  - rs==0 gives 0.
  - else mem_valid & mem_we & mem_rd_addr==rs gives mem_result.
  - else wb_we & wb_rd_addr==rs gives wb_data.
  - else the registered value.
  - MEM beats WB, because it is the newer producer.
  - A load in MEM is never forwarded from mem_result; the load-use stall guarantees this case never arises.
- Latency: one cycle from ID capture to EX outputs. No combinational path from id_* to ex_* outputs.
- Reset mid-hold or mid-stall: state clears next edge and stall_id drops.
- A bubble (ex_valid=0) forces ex_we, ex_mem_read and ex_mem_write to 0; ex_op_a/b are don't-care.

Decomposition:
- Shared package (core_pkg): ALU opcode localparams, word_size/addr_width defaults, ZERO_REG constant, bubble control-bundle constant.
- One sub-module: operand_forward (address, registered value, MEM/WB ports in; forwarded value out), instantiated twice.

Test Plan:
- Reset: rst=1 for two cycles with id_valid=1 gives ex_valid=0, all outputs 0, stall_id=0; first post-reset edge captures id_imm=0x1234 onto ex_imm.
- Load-use: lw to R3 in EX, ID reads R3 → stall_id=1 for exactly one cycle and a bubble next cycle; the following cycle ex_op_a equals wb_data=0xBEEF forwarded from WB.
- Forward priority: ID reads R5; MEM writes R5=0x0011 while WB writes R5=0x0022 → ex_op_a=0x0011; rs=R0 with mem_rd_addr=0 → 0x0000.
- Hold: ex_hold=1 for 3 cycles while WB forwards 0x00AA into op_b, then WB moves on → ex_op_b stays 0x00AA, stall_id=1 throughout, all fields unchanged.
- Flush vs hold/stall: flush=1 together with ex_hold=1 and a load-use hit → next cycle ex_valid=0, ex_we=0, stall_id=0 during the flush cycle.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit RISC-V core pipeline.
// Covers datapath widths, ALU opcodes, and the EX control bundle.
package core_pkg;

    localparam int unsigned WORD_SIZE    = 16;
    localparam int unsigned ADDR_WIDTH   = 4;
    localparam int unsigned ALU_OP_WIDTH = 4;

    localparam logic [ADDR_WIDTH-1:0] ZERO_REG = '0;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 4'h0;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 4'h1;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 4'h2;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 4'h3;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 4'h4;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = 4'h5;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = 4'h6;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = 4'h7;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT  = 4'h8;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = 4'h9;

    typedef struct packed {
        logic we;
        logic mem_read;
        logic mem_write;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{we: 1'b0, mem_read: 1'b0, mem_write: 1'b0};

endpackage

// File: rtl/operand_forward.sv
// Selects one EX operand from MEM, WB or the registered value.
// MEM wins over WB because it holds the newer producer.
module operand_forward
    import core_pkg::*;
#(
    parameter int unsigned WordSize  = WORD_SIZE,
    parameter int unsigned AddrWidth = ADDR_WIDTH
) (
    input  logic [AddrWidth-1:0] rs_addr_i,
    input  logic [WordSize-1:0]  reg_val_i,
    input  logic                 mem_valid_i,
    input  logic                 mem_we_i,
    input  logic [AddrWidth-1:0] mem_rd_addr_i,
    input  logic [WordSize-1:0]  mem_result_i,
    input  logic                 wb_we_i,
    input  logic [AddrWidth-1:0] wb_rd_addr_i,
    input  logic [WordSize-1:0]  wb_data_i,
    output logic [WordSize-1:0]  fwd_val_o
);

    always_comb begin
        fwd_val_o = reg_val_i;
        if (rs_addr_i == ZERO_REG) begin
            fwd_val_o = '0;
        end else if (mem_valid_i && mem_we_i && (mem_rd_addr_i == rs_addr_i)) begin
            fwd_val_o = mem_result_i;
        end else if (wb_we_i && (wb_rd_addr_i == rs_addr_i)) begin
            fwd_val_o = wb_data_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush, hold and MEM/WB operand forwarding.
// Distance-3 forwarding (WB to ID) is handled inside the register bank, not here.
module id_ex_stage
    import core_pkg::*;
#(
    parameter int unsigned WordSize   = WORD_SIZE,
    parameter int unsigned AddrWidth  = ADDR_WIDTH,
    parameter int unsigned AluOpWidth = ALU_OP_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid_i,
    input  logic [AddrWidth-1:0]  id_rs1_addr_i,
    input  logic [AddrWidth-1:0]  id_rs2_addr_i,
    input  logic [AddrWidth-1:0]  id_rd_addr_i,
    input  logic [WordSize-1:0]   id_rs1_data_i,
    input  logic [WordSize-1:0]   id_rs2_data_i,
    input  logic [WordSize-1:0]   id_imm_i,
    input  logic [AluOpWidth-1:0] id_alu_op_i,
    input  logic                  id_we_i,
    input  logic                  id_mem_read_i,
    input  logic                  id_mem_write_i,
    input  logic                  flush_i,
    input  logic                  ex_hold_i,
    input  logic                  mem_valid_i,
    input  logic                  mem_we_i,
    input  logic [AddrWidth-1:0]  mem_rd_addr_i,
    input  logic [WordSize-1:0]   mem_result_i,
    input  logic                  wb_we_i,
    input  logic [AddrWidth-1:0]  wb_rd_addr_i,
    input  logic [WordSize-1:0]   wb_data_i,
    output logic                  stall_id_o,
    output logic                  ex_valid_o,
    output logic [AddrWidth-1:0]  ex_rd_addr_o,
    output logic [WordSize-1:0]   ex_op_a_o,
    output logic [WordSize-1:0]   ex_op_b_o,
    output logic [WordSize-1:0]   ex_imm_o,
    output logic [AluOpWidth-1:0] ex_alu_op_o,
    output logic                  ex_we_o,
    output logic                  ex_mem_read_o,
    output logic                  ex_mem_write_o
);

    logic                  valid_q, valid_d;
    logic [AddrWidth-1:0]  rs1_q, rs1_d;
    logic [AddrWidth-1:0]  rs2_q, rs2_d;
    logic [AddrWidth-1:0]  rd_q, rd_d;
    logic [WordSize-1:0]   op_a_q, op_a_d;
    logic [WordSize-1:0]   op_b_q, op_b_d;
    logic [WordSize-1:0]   imm_q, imm_d;
    logic [AluOpWidth-1:0] alu_op_q, alu_op_d;
    ctrl_t                 ctrl_q, ctrl_d;

    logic load_use;

    operand_forward #(
        .WordSize  (WordSize),
        .AddrWidth (AddrWidth)
    ) u_fwd_a (
        .rs_addr_i     (rs1_q),
        .reg_val_i     (op_a_q),
        .mem_valid_i   (mem_valid_i),
        .mem_we_i      (mem_we_i),
        .mem_rd_addr_i (mem_rd_addr_i),
        .mem_result_i  (mem_result_i),
        .wb_we_i       (wb_we_i),
        .wb_rd_addr_i  (wb_rd_addr_i),
        .wb_data_i     (wb_data_i),
        .fwd_val_o     (ex_op_a_o)
    );

    operand_forward #(
        .WordSize  (WordSize),
        .AddrWidth (AddrWidth)
    ) u_fwd_b (
        .rs_addr_i     (rs2_q),
        .reg_val_i     (op_b_q),
        .mem_valid_i   (mem_valid_i),
        .mem_we_i      (mem_we_i),
        .mem_rd_addr_i (mem_rd_addr_i),
        .mem_result_i  (mem_result_i),
        .wb_we_i       (wb_we_i),
        .wb_rd_addr_i  (wb_rd_addr_i),
        .wb_data_i     (wb_data_i),
        .fwd_val_o     (ex_op_b_o)
    );

    assign load_use = valid_q && ctrl_q.mem_read && (rd_q != ZERO_REG) && id_valid_i &&
                      ((rd_q == id_rs1_addr_i) || (rd_q == id_rs2_addr_i));

    assign stall_id_o = !rst && !flush_i && (ex_hold_i || load_use);

    always_comb begin
        valid_d  = valid_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        rd_d     = rd_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        imm_d    = imm_q;
        alu_op_d = alu_op_q;
        ctrl_d   = ctrl_q;
        if (flush_i || (!ex_hold_i && load_use)) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_BUBBLE;
        end else if (ex_hold_i) begin
            // Re-latch forwarded operands so a producer retiring during the hold is kept.
            op_a_d = ex_op_a_o;
            op_b_d = ex_op_b_o;
        end else begin
            valid_d  = id_valid_i;
            rs1_d    = id_rs1_addr_i;
            rs2_d    = id_rs2_addr_i;
            rd_d     = id_rd_addr_i;
            op_a_d   = id_rs1_data_i;
            op_b_d   = id_rs2_data_i;
            imm_d    = id_imm_i;
            alu_op_d = id_alu_op_i;
            ctrl_d   = '{we: id_we_i, mem_read: id_mem_read_i, mem_write: id_mem_write_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            imm_q    <= '0;
            alu_op_q <= '0;
            ctrl_q   <= CTRL_BUBBLE;
        end else begin
            valid_q  <= valid_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            imm_q    <= imm_d;
            alu_op_q <= alu_op_d;
            ctrl_q   <= ctrl_d;
        end
    end

    assign ex_valid_o     = valid_q;
    assign ex_rd_addr_o   = rd_q;
    assign ex_imm_o       = imm_q;
    assign ex_alu_op_o    = alu_op_q;
    assign ex_we_o        = valid_q & ctrl_q.we;
    assign ex_mem_read_o  = valid_q & ctrl_q.mem_read;
    assign ex_mem_write_o = valid_q & ctrl_q.mem_write;

endmodule
